// File: rtl/interval_timer.sv
// Interval timer: counts enabled cycles up to a run-time terminal value and pulses ovflw on each hit.
// Supports one-shot and periodic modes, pause or clear on enable loss, abort, and a saturating hit counter.
module interval_timer #(
   parameter int WIDTH            = 32,
   parameter int OVF_WIDTH        = 8,
   parameter bit CLEAR_ON_DISABLE = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 start,
   input  logic                 abort,
   input  logic                 periodic,
   input  logic [WIDTH-1:0]     terminal,
   output logic [WIDTH-1:0]     cnt,
   output logic                 ovflw,
   output logic [OVF_WIDTH-1:0] ovf_count,
   output logic                 busy,
   output logic                 done
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] COUNT = 2'd1;
   localparam logic [1:0] PAUSE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [WIDTH-1:0]     CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [OVF_WIDTH-1:0] OVF_ONE = {{(OVF_WIDTH-1){1'b0}}, 1'b1};

   logic [1:0]       state;
   logic [WIDTH-1:0] term_reg;
   logic             mode_reg;

   // Hit counter sticks at all-ones instead of wrapping.
   function automatic logic [OVF_WIDTH-1:0] sat_inc(input logic [OVF_WIDTH-1:0] v);
      return (&v) ? v : v + OVF_ONE;
   endfunction

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         cnt       <= '0;
         ovflw     <= 1'b0;
         ovf_count <= '0;
         term_reg  <= '0;
         mode_reg  <= 1'b0;
      end else begin
         ovflw <= 1'b0;
         if (abort) begin
            state     <= IDLE;
            cnt       <= '0;
            ovf_count <= '0;
         end else if (start && (state == IDLE || state == DONE)) begin
            term_reg  <= terminal;
            mode_reg  <= periodic;
            cnt       <= '0;
            ovf_count <= '0;
            state     <= COUNT;
         end else begin
            case (state)
               COUNT: begin
                  if (!enable) begin
                     if (CLEAR_ON_DISABLE) begin
                        state <= IDLE;
                        cnt   <= '0;
                     end else begin
                        state <= PAUSE;
                     end
                  end else if (cnt == term_reg) begin
                     cnt       <= '0;
                     ovflw     <= 1'b1;
                     ovf_count <= sat_inc(ovf_count);
                     state     <= mode_reg ? COUNT : DONE;
                  end else begin
                     cnt <= cnt + CNT_ONE;
                  end
               end
               // Resuming edge only re-enters COUNT; the increment starts on the following edge.
               PAUSE: begin
                  if (enable) state <= COUNT;
               end
               default: ;
            endcase
         end
      end
   end

   assign busy = (state == COUNT) || (state == PAUSE);
   assign done = (state == DONE);

endmodule

// File: tb/tb_interval_timer.sv
// Bench for interval_timer: three instances (pause / clear-on-disable / 2-bit hit counter) against a reference model.
module tb_interval_timer;
   localparam int W = 8;
   localparam int M_IDLE = 0, M_COUNT = 1, M_PAUSE = 2, M_DONE = 3;

   logic clk = 1'b0, reset = 1'b1;
   logic start = 1'b0, abort = 1'b0, enable = 1'b0, periodic = 1'b0;
   logic [W-1:0] terminal = '0;
   logic [W-1:0] cnt_w [3];
   logic ovflw_w [3];
   logic busy_w [3];
   logic done_w [3];
   logic [7:0] ovf0, ovf1;
   logic [1:0] ovf2;
   int checks = 0, failures = 0;

   always #5 clk = ~clk;

   interval_timer #(.WIDTH(W), .OVF_WIDTH(8), .CLEAR_ON_DISABLE(1'b0)) dut0 (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .abort(abort),
      .periodic(periodic), .terminal(terminal), .cnt(cnt_w[0]), .ovflw(ovflw_w[0]),
      .ovf_count(ovf0), .busy(busy_w[0]), .done(done_w[0]));
   interval_timer #(.WIDTH(W), .OVF_WIDTH(8), .CLEAR_ON_DISABLE(1'b1)) dut1 (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .abort(abort),
      .periodic(periodic), .terminal(terminal), .cnt(cnt_w[1]), .ovflw(ovflw_w[1]),
      .ovf_count(ovf1), .busy(busy_w[1]), .done(done_w[1]));
   interval_timer #(.WIDTH(W), .OVF_WIDTH(2), .CLEAR_ON_DISABLE(1'b0)) dut2 (
      .clk(clk), .reset(reset), .enable(enable), .start(start), .abort(abort),
      .periodic(periodic), .terminal(terminal), .cnt(cnt_w[2]), .ovflw(ovflw_w[2]),
      .ovf_count(ovf2), .busy(busy_w[2]), .done(done_w[2]));

   typedef struct {int st; int cnt; int term; int mode; int ovf; int pulse;} mdl_t;
   mdl_t m [3];

   typedef struct {int s; int a; int e; int p; int t; int c; int o; int oc; int b; int dn;} vec_t;
   vec_t vq [$];

   function automatic int ovf_of(input int d);
      if (d == 0) return int'(ovf0);
      if (d == 1) return int'(ovf1);
      return int'(ovf2);
   endfunction

   // Reference behaviour from the timer's rules; hit counter capped at each instance's maximum.
   function automatic mdl_t mstep(input mdl_t q, input int d);
      mdl_t n;
      int ovf_max;
      n = q;
      n.pulse = 0;
      ovf_max = (d == 2) ? 3 : 255;
      if (abort) begin
         n.st = M_IDLE; n.cnt = 0; n.ovf = 0;
      end else if (start && (q.st == M_IDLE || q.st == M_DONE)) begin
         n.term = int'(terminal); n.mode = periodic ? 1 : 0;
         n.cnt = 0; n.ovf = 0; n.st = M_COUNT;
      end else if (q.st == M_COUNT && !enable) begin
         if (d == 1) begin n.st = M_IDLE; n.cnt = 0; end
         else n.st = M_PAUSE;
      end else if (q.st == M_COUNT && q.cnt == q.term) begin
         n.cnt = 0; n.pulse = 1;
         n.ovf = (q.ovf < ovf_max) ? q.ovf + 1 : ovf_max;
         n.st = (q.mode != 0) ? M_COUNT : M_DONE;
      end else if (q.st == M_COUNT) begin
         n.cnt = q.cnt + 1;
      end else if (q.st == M_PAUSE && enable) begin
         n.st = M_COUNT;
      end
      return n;
   endfunction

   task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s dut%0d actual=%0d required=%0d", name, d, act, exp);
      end
   endtask

   task automatic mreset();
      for (int d = 0; d < 3; d++) m[d] = '{M_IDLE, 0, 0, 0, 0, 0};
   endtask

   task automatic check_models();
      for (int d = 0; d < 3; d++) begin
         check("cnt", d, 32'(cnt_w[d]), m[d].cnt);
         check("ovflw", d, 32'(ovflw_w[d]), m[d].pulse);
         check("ovf_count", d, ovf_of(d), m[d].ovf);
         check("busy", d, 32'(busy_w[d]), (m[d].st == M_COUNT || m[d].st == M_PAUSE) ? 1 : 0);
         check("done", d, 32'(done_w[d]), (m[d].st == M_DONE) ? 1 : 0);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int d = 0; d < 3; d++) m[d] = mstep(m[d], d);
      #1;
      check_models();
   endtask

   task automatic drive(input int s, input int a, input int e, input int p, input int t);
      start = (s != 0); abort = (a != 0); enable = (e != 0); periodic = (p != 0);
      terminal = t[W-1:0];
   endtask

   task automatic add(input int s, a, e, p, t, c, o, oc, b, dn);
      vec_t v;
      v = '{s, a, e, p, t, c, o, oc, b, dn};
      vq.push_back(v);
   endtask

   initial begin
      mreset();
      // Periodic, terminal 4: pulses on edges 5, 10, 15 after start.
      add(1, 0, 1, 1, 4, 0, 0, 0, 1, 0);
      for (int i = 1; i <= 16; i++) add(0, 0, 1, 1, 4, i % 5, (i % 5 == 0) ? 1 : 0, i / 5, 1, 0);
      add(0, 1, 1, 1, 4, 0, 0, 0, 0, 0);
      // One-shot, terminal 2; then restart from DONE.
      add(1, 0, 1, 0, 2, 0, 0, 0, 1, 0);
      add(0, 0, 1, 0, 2, 1, 0, 0, 1, 0);
      add(0, 0, 1, 0, 2, 2, 0, 0, 1, 0);
      add(0, 0, 1, 0, 2, 0, 1, 1, 0, 1);
      add(0, 0, 1, 0, 2, 0, 0, 1, 0, 1);
      add(0, 0, 1, 0, 2, 0, 0, 1, 0, 1);
      add(1, 0, 1, 0, 2, 0, 0, 0, 1, 0);
      add(0, 0, 1, 0, 2, 1, 0, 0, 1, 0);

      #1;
      for (int d = 0; d < 3; d++) begin
         check("rst_cnt", d, 32'(cnt_w[d]), 0);
         check("rst_ovflw", d, 32'(ovflw_w[d]), 0);
         check("rst_busy", d, 32'(busy_w[d]), 0);
         check("rst_done", d, 32'(done_w[d]), 0);
      end
      check("rst_ovf", 2, ovf_of(2), 0);
      #10 reset = 1'b0;

      foreach (vq[i]) begin
         drive(vq[i].s, vq[i].a, vq[i].e, vq[i].p, vq[i].t);
         cycle();
         check("tbl_cnt", 0, 32'(cnt_w[0]), vq[i].c);
         check("tbl_ovflw", 0, 32'(ovflw_w[0]), vq[i].o);
         check("tbl_ovf_count", 0, 32'(ovf0), vq[i].oc);
         check("tbl_busy", 0, 32'(busy_w[0]), vq[i].b);
         check("tbl_done", 0, 32'(done_w[0]), vq[i].dn);
      end

      // Pause vs clear: terminal 9, enable lost at cnt 6 for 5 cycles.
      drive(0, 1, 1, 0, 9); cycle();
      drive(1, 0, 1, 0, 9); cycle();
      drive(0, 0, 1, 0, 9);
      repeat (6) cycle();
      check("pre_pause_cnt", 0, 32'(cnt_w[0]), 6);
      drive(0, 0, 0, 0, 9);
      repeat (5) cycle();
      check("pause_cnt", 0, 32'(cnt_w[0]), 6);
      check("pause_busy", 0, 32'(busy_w[0]), 1);
      check("clr_cnt", 1, 32'(cnt_w[1]), 0);
      check("clr_busy", 1, 32'(busy_w[1]), 0);
      drive(0, 0, 1, 0, 9); cycle();
      check("resume_cnt", 0, 32'(cnt_w[0]), 6);
      for (int i = 1; i <= 4; i++) begin
         cycle();
         check("resume_ovflw", 0, 32'(ovflw_w[0]), (i == 4) ? 1 : 0);
         check("clr_ovflw", 1, 32'(ovflw_w[1]), 0);
      end

      // Periodic terminal 0: continuous pulse, 2-bit counter saturates.
      drive(0, 1, 1, 1, 0); cycle();
      drive(1, 0, 1, 1, 0); cycle();
      drive(0, 0, 1, 1, 0);
      for (int i = 0; i < 6; i++) begin
         cycle();
         check("t0_ovflw", 2, 32'(ovflw_w[2]), 1);
      end
      check("t0_sat", 2, 32'(ovf2), 3);
      check("t0_count", 0, 32'(ovf0), 6);

      // Abort together with start at cnt 3.
      drive(1, 0, 1, 1, 9); cycle();
      drive(0, 0, 1, 1, 9); cycle();
      drive(0, 1, 1, 1, 9); cycle();
      drive(1, 0, 1, 1, 9); cycle();
      drive(0, 0, 1, 1, 9);
      repeat (3) cycle();
      check("pre_abort_cnt", 0, 32'(cnt_w[0]), 3);
      drive(1, 1, 1, 1, 5); cycle();
      check("abort_cnt", 0, 32'(cnt_w[0]), 0);
      check("abort_busy", 0, 32'(busy_w[0]), 0);
      check("abort_ovf", 0, 32'(ovf0), 0);
      drive(0, 0, 1, 1, 5); cycle();
      check("abort_idle", 0, 32'(busy_w[0]), 0);

      // Asynchronous reset mid-count, checked before the next edge.
      drive(1, 0, 1, 1, 20); cycle();
      drive(0, 0, 1, 1, 20);
      repeat (4) cycle();
      #3 reset = 1'b1;
      #1;
      for (int d = 0; d < 3; d++) begin
         check("areset_cnt", d, 32'(cnt_w[d]), 0);
         check("areset_ovf", d, ovf_of(d), 0);
         check("areset_busy", d, 32'(busy_w[d]), 0);
      end
      mreset();
      #3 reset = 1'b0;

      // Terminal change during COUNT has no effect until the next start.
      drive(1, 0, 1, 0, 7); cycle();
      drive(0, 0, 1, 0, 7); cycle(); cycle();
      drive(1, 0, 1, 0, 2); cycle();
      drive(0, 0, 1, 0, 2);
      for (int i = 4; i <= 8; i++) begin
         cycle();
         check("tchg_ovflw", 0, 32'(ovflw_w[0]), (i == 8) ? 1 : 0);
      end
      drive(1, 0, 1, 0, 2); cycle();
      drive(0, 0, 1, 0, 2);
      for (int i = 1; i <= 3; i++) begin
         cycle();
         check("tnew_ovflw", 0, 32'(ovflw_w[0]), (i == 3) ? 1 : 0);
      end

      // All-ones terminal: no wrap before the match.
      drive(1, 0, 1, 0, 255); cycle();
      drive(0, 0, 1, 0, 255);
      for (int i = 1; i <= 256; i++) begin
         cycle();
         if (i == 255) check("max_cnt", 0, 32'(cnt_w[0]), 255);
         if (i == 256) check("max_ovflw", 0, 32'(ovflw_w[0]), 1);
      end

      // Randomised traffic against the model.
      for (int i = 0; i < 3000; i++) begin
         drive(($urandom_range(0, 11) == 0) ? 1 : 0,
               ($urandom_range(0, 79) == 0) ? 1 : 0,
               ($urandom_range(0, 7) != 0) ? 1 : 0,
               int'($urandom_range(0, 1)),
               ($urandom_range(0, 19) == 0) ? 255 : int'($urandom_range(0, 10)));
         cycle();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
